mem_burst_master: RTL and testbench

- Initiator-side engine for the main memory port: turns one client request into a single or burst (1/4/8/16-word) read or write on the mainMem interface (addr, data_in, data_out, acc_size, wren, busy, enable).
- Sits between the fetch/load-store logic and mainMem.
- Sequences address, write data and burst size, and honours busy.
- Collects read beats after the fixed memory latency and streams them back to the client.

---
 rtl/mem_burst_master.sv | 91 +++++++++
 tb/tb_mem_burst_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// mem_burst_master: turns one client request into a single or burst read/write on the mainMem port.
module mem_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [1:0]        mem_acc_size,
    output logic              mem_wren,
    output logic              mem_enable,
    input  logic              mem_busy
);
    localparam int LW = READ_LATENCY > 2 ? $clog2(READ_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_END = LW'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {IDLE, WRITE, RD_WAIT, READ, FIN} state_t;

    state_t          state, state_nx;
    logic [4:0]      beat, last;
    logic [LW-1:0]   lat;
    logic            pend, accept, beat_go;

    always_comb begin
        last       = mem_acc_size == 2'd0 ? 5'd0 : mem_acc_size == 2'd1 ? 5'd3 :
                     mem_acc_size == 2'd2 ? 5'd7 : 5'd15;
        accept     = state == IDLE && req_valid && req_addr[1:0] == 2'b00;
        beat_go    = state == WRITE && !mem_busy;
        req_ready  = state == IDLE;
        wr_pop     = reset_n && ((accept && req_write) || (beat_go && beat != last));
        mem_enable = state == WRITE || state == RD_WAIT || state == READ;
        mem_wren   = state == WRITE;
        done       = state == FIN;
        state_nx   = state;
        case (state)
            IDLE:    state_nx = accept ? (req_write ? WRITE : RD_WAIT) : IDLE;
            WRITE:   state_nx = beat_go && beat == last ? FIN : WRITE;
            // pend marks the read command not yet taken by the memory
            RD_WAIT: state_nx = (pend ? !mem_busy && READ_LATENCY == 1 : lat == LAT_END) ? READ : RD_WAIT;
            READ:    state_nx = beat == last ? FIN : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            beat         <= '0;
            lat          <= '0;
            pend         <= 1'b0;
            mem_addr     <= '0;
            mem_acc_size <= '0;
            mem_data_in  <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            error        <= 1'b0;
        end else begin
            state    <= state_nx;
            error    <= state == IDLE && req_valid && req_addr[1:0] != 2'b00;
            rd_valid <= state == READ;
            if (state == READ) rd_data <= mem_data_out;
            if (accept) begin
                mem_addr     <= req_addr;
                mem_acc_size <= req_size;
                beat         <= '0;
                lat          <= '0;
                pend         <= 1'b1;
            end
            if (wr_pop) mem_data_in <= wr_data;
            if ((beat_go && beat != last) || state == READ) beat <= beat + 5'd1;
            if (state == RD_WAIT) begin
                if (pend) pend <= mem_busy;
                else lat <= lat + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: directed and randomized bench with a mainMem model and a word-level reference memory.
module tb_mem_burst_master;
    localparam int L = 2;

    logic        clock = 0, reset_n = 0;
    logic        req_valid = 0, req_write = 0, req_ready;
    logic [31:0] req_addr = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] wr_data, rd_data, mem_addr, mem_data_in, mem_data_out = 0;
    logic        wr_pop, rd_valid, done, error, mem_wren, mem_enable, mem_busy = 0;
    logic [1:0]  mem_acc_size;

    always #5 clock = ~clock;

    mem_burst_master #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .wr_data(wr_data),
        .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_acc_size(mem_acc_size), .mem_wren(mem_wren), .mem_enable(mem_enable), .mem_busy(mem_busy)
    );

    int checks = 0, errors = 0;
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dat[16];

    logic [31:0] wbuf[32];
    logic [4:0]  widx = 0;
    assign wr_data = wbuf[widx];
    always @(posedge clock) if (wr_pop) widx <= widx + 5'd1;

    logic [31:0] dmem[4096];
    int          cyc = 0, cyc0 = 0, wk = 0, stall_cyc = 0, stall_bad = 0;
    logic        rd_act = 0, pbusy = 0;
    logic [31:0] raddr = 0, pdin = 0;
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        pbusy <= mem_enable && mem_wren && mem_busy;
        pdin  <= mem_data_in;
        if (pbusy && mem_data_in !== pdin) stall_bad <= stall_bad + 1;
        if (mem_enable && mem_busy && (mem_wren || !rd_act)) stall_cyc <= stall_cyc + 1;
        if (!mem_enable) begin
            wk     <= 0;
            rd_act <= 0;
        end else if (!mem_busy && mem_wren) begin
            dmem[12'((mem_addr >> 2) + wk)] <= mem_data_in;
            wk <= wk + 1;
        end else if (!mem_busy && !rd_act) begin
            rd_act <= 1;
            cyc0   <= cyc;
            raddr  <= mem_addr;
        end
    end
    always @(negedge clock)
        mem_data_out <= (rd_act && cyc - cyc0 - L >= 0 && cyc - cyc0 - L < 16) ?
                        dmem[12'((raddr >> 2) + (cyc - cyc0 - L))] : (32'hBAD00000 | cyc);

    bit busy_q[$];
    bit rand_busy = 0;
    always @(posedge clock) begin
        #1;
        if (mem_enable && busy_q.size() > 0) mem_busy = busy_q.pop_front();
        else mem_busy = rand_busy && mem_enable && $urandom_range(3) == 0;
    end

    logic [31:0] xaddr = 0;
    logic [1:0]  xsize = 0;
    logic        xwr = 0;
    int          tot_pop = 0, tot_done = 0, tot_err = 0, addr_bad = 0, pop_bad = 0, rd_n = 0, done_cyc = 0;
    logic [31:0] rd_log[2048];
    int          rd_cyc[2048];
    always @(negedge clock) begin
        if (wr_pop) tot_pop <= tot_pop + 1;
        if (done) begin
            tot_done <= tot_done + 1;
            done_cyc <= cyc;
        end
        if (error) tot_err <= tot_err + 1;
        if (mem_busy && mem_wren && wr_pop) pop_bad <= pop_bad + 1;
        if (mem_enable && (mem_addr !== xaddr || mem_acc_size !== xsize || mem_wren !== xwr))
            addr_bad <= addr_bad + 1;
        if (rd_valid) begin
            rd_log[rd_n] <= rd_data;
            rd_cyc[rd_n] <= cyc;
            rd_n <= rd_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int acc_cyc;
    task automatic xact(input bit wr, input logic [31:0] a, input logic [1:0] sz);
        int n, p0, d0, r0, ab0, sb0, pb0, to;
        n = sz == 2'd0 ? 1 : 1 << (sz + 1);
        xaddr = a; xsize = sz; xwr = wr;
        if (wr) for (int i = 0; i < n; i++) begin
            wbuf[5'(widx + i)] = dat[i];
            ref_mem[a + 32'(4 * i)] = dat[i];
        end
        p0 = tot_pop; d0 = tot_done; r0 = rd_n; ab0 = addr_bad; sb0 = stall_bad; pb0 = pop_bad;
        @(posedge clock); #1;
        req_valid = 1; req_write = wr; req_addr = a; req_size = sz;
        @(negedge clock);
        chk("accept_ready", req_ready, 1);
        chk("accept_pop", wr_pop, wr);
        acc_cyc = cyc;
        @(posedge clock); #1;
        req_valid = 0;
        @(negedge clock);
        chk("cmd_enable", mem_enable, 1);
        to = 0;
        while (tot_done == d0 && to < 300) begin
            @(negedge clock);
            to++;
        end
        @(posedge clock); #1;
        chk("done_once", tot_done - d0, 1);
        chk("ready_after", req_ready, 1);
        chk("cmd_stable", addr_bad - ab0, 0);
        if (wr) begin
            chk("pop_count", tot_pop - p0, n);
            chk("stall_hold", stall_bad - sb0, 0);
            chk("stall_pop", pop_bad - pb0, 0);
        end else begin
            chk("rd_count", rd_n - r0, n);
            chk("rd_latency", rd_cyc[r0] - cyc0, L + 1);
            chk("rd_consec", rd_cyc[r0 + n - 1] - rd_cyc[r0], n - 1);
            for (int i = 0; i < n; i++) chk($sformatf("rd_data[%0d]", i), rd_log[r0 + i], ref_mem[a + 32'(4 * i)]);
        end
    endtask

    initial begin
        int s0, r0, d0, to;
        #3;
        chk("reset_outs", {mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable, wr_pop, rd_data, rd_valid, done, error}, 0);
        chk("reset_ready", req_ready, 1);
        @(posedge clock); #1;
        reset_n = 1;

        dat[0] = 32'h27BDFFE8;
        xact(1, 32'h80020000, 2'd0);
        chk("single_wr_done_time", done_cyc - acc_cyc, 2);
        xact(0, 32'h80020000, 2'd0);

        dat[0] = 32'hAFBF0014; dat[1] = 32'hAFBE0010; dat[2] = 32'h03A0F021; dat[3] = 32'h3C1C1001;
        xact(1, 32'h80020004, 2'd1);
        xact(0, 32'h80020004, 2'd1);

        for (int i = 0; i < 16; i++) dat[i] = $urandom;
        busy_q = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        s0 = stall_cyc;
        xact(1, 32'h80020100, 2'd3);
        chk("stall_cycles", stall_cyc - s0, 5);
        xact(0, 32'h80020100, 2'd3);

        s0 = tot_err;
        @(posedge clock); #1;
        req_valid = 1; req_write = 1; req_addr = 32'h80020002; req_size = 2'd0;
        @(posedge clock); #1;
        req_valid = 0;
        @(negedge clock);
        chk("misalign_error", error, 1);
        chk("misalign_enable", mem_enable, 0);
        chk("misalign_ready", req_ready, 1);
        @(negedge clock);
        chk("misalign_pulse", tot_err - s0, 1);
        chk("misalign_idle", mem_enable, 0);

        r0 = rd_n;
        xaddr = 32'h80020100; xsize = 2'd2; xwr = 0;
        @(posedge clock); #1;
        req_valid = 1; req_write = 0; req_addr = 32'h80020100; req_size = 2'd2;
        @(posedge clock); #1;
        req_valid = 0;
        to = 0;
        while (rd_n - r0 < 3 && to < 100) begin
            @(posedge clock); #1;
            to++;
        end
        chk("reset_beat3_reached", rd_n - r0, 3);
        reset_n = 0;
        #1;
        chk("midreset_outs", {mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable, wr_pop, rd_data, rd_valid, done, error}, 0);
        chk("midreset_ready", req_ready, 1);
        @(posedge clock); #3;
        reset_n = 1;
        r0 = rd_n; d0 = tot_done;
        repeat (6) @(negedge clock);
        chk("post_reset_no_rd", rd_n - r0, 0);
        chk("post_reset_no_done", tot_done - d0, 0);
        dat[0] = 32'h12345678;
        xact(1, 32'h80020040, 2'd0);
        xact(0, 32'h80020040, 2'd0);

        rand_busy = 1;
        for (int t = 0; t < 12; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a = 32'h80020000 + ($urandom_range(0, 255) << 6);
            sz = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) dat[i] = $urandom;
            xact(1, a, sz);
            xact(0, a, sz);
        end
        rand_busy = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
